freq_gate_sequencer: RTL
========================

FREQ_GATE_SEQUENCER -- requirements
Module: freq_gate_sequencer

Interface
REQ-001 Parameter GATE_CYCLES, default 1000, gate window length in clk cycles at range 0.
REQ-002 Parameter SETTLE_CYCLES, default 4, post-gate wait for counter CDC synchronizer to settle.
REQ-003 Parameter CW, default 24, count/result width.
REQ-004 Parameter LOW_THRESH, default 100, autorange step-up threshold.
REQ-005 clk  input  1  reference clock; the only clock.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  run continuous measurements while high.
REQ-008 cnt_value  input  CW  X-clock counter value, already synchronized to clk.
REQ-009 cnt_clear  output  1  single-cycle clear pulse to counter.
REQ-010 gate_en  output  1  counter gate; counter counts only while high.
REQ-011 result  output  CW  latched measurement.
REQ-012 overflow  output  1  result saturated (cnt_value all ones).
REQ-013 range  output  2  current decade range (0..2).
REQ-014 disp_req  output  1  result ready for display, held until acked.
REQ-015 disp_ack  input  1  display has consumed result.

Function
REQ-016 FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH, REQ; all outputs registered.
REQ-017 IDLE: enable=1 -> CLEAR next cycle; otherwise stay.
REQ-018 CLEAR: cnt_clear=1 for exactly one cycle -> GATE.
REQ-019 GATE: gate_en=1 for exactly GATE_CYCLES*10^range cycles -> SETTLE; gate counter width clog2(GATE_CYCLES*100+1).
REQ-020 SETTLE: gate_en=0 for exactly SETTLE_CYCLES cycles -> LATCH.
REQ-021 LATCH: one cycle; result<=cnt_value; overflow<=(cnt_value=={CW{1}}) -> REQ.
REQ-022 REQ: disp_req=1 until disp_ack sampled high; disp_req drops next cycle; then CLEAR if enable else IDLE.
REQ-023 disp_ack ignored when disp_req=0; ack in first disp_req cycle accepted.
REQ-024 result, overflow, range stable whenever disp_req=1.
REQ-025 enable low in CLEAR/GATE/SETTLE: abort to IDLE next cycle, gate_en low, result unchanged, no disp_req.
REQ-026 enable low in LATCH/REQ: finish handshake, then IDLE.
REQ-027 Measurement latency enable-rise to disp_req: 1+1+gate+SETTLE_CYCLES+1+1 cycles.

Reset
REQ-028 rst_n low: state IDLE, cnt_clear=0, gate_en=0, result=0, overflow=0, range=0, disp_req=0, gate counter=0, immediately and asynchronously, including mid-gate or mid-handshake.

Configuration
REQ-029 FREQ_GATE_SEQUENCER_AUTORANGE_EN defined: in LATCH, overflow and range>0 -> range-1; else cnt_value<LOW_THRESH and range<2 -> range+1; new range applies to next gate; range is the range of the latched result until next LATCH.
REQ-030 Macro undefined: range tied 0, gate always GATE_CYCLES, no range logic synthesized.

Structure
REQ-031 Shared package holds FSM state enum, range encoding, decade scale constants (1,10,100).
REQ-032 One sub-module gate_timer: loadable down-counter with terminal-count flag, reused for GATE and SETTLE.

Verification
REQ-033 GATE_CYCLES=10, enable=1, cnt_value=500 -> cnt_clear 1 cycle, gate_en 10 cycles, disp_req after 4 settle cycles, result=500.
REQ-034 disp_ack held low 50 cycles -> disp_req held, result stable; ack -> disp_req low next cycle, next cnt_clear follows.
REQ-035 enable dropped at gate cycle 5 -> gate_en low next cycle, IDLE, no disp_req, result unchanged.
REQ-036 cnt_value=24'hFFFFFF -> overflow=1; with macro and range=1, range becomes 0.
REQ-037 Macro defined, cnt_value=50 twice -> range 1 then 2, gate lengths 100 then 1000 cycles; third stays 2.
REQ-038 rst_n low mid-GATE and mid-REQ -> all outputs zero immediately; restart from IDLE after release.

Source files
------------

// File: rtl/freq_gate_sequencer_pkg.sv
// Shared types for the frequency gate sequencer: FSM states, decade range
// encoding and the decade scale factors applied to the base gate window.
package freq_gate_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4,
        ST_REQ    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        RANGE_X1   = 2'd0,
        RANGE_X10  = 2'd1,
        RANGE_X100 = 2'd2
    } range_e;

    localparam logic [1:0]  RANGE_MAX      = 2'd2;
    localparam int unsigned DECADE_SCALE_0 = 1;
    localparam int unsigned DECADE_SCALE_1 = 10;
    localparam int unsigned DECADE_SCALE_2 = 100;

    function automatic int unsigned decade_scale(input logic [1:0] rng);
        case (rng)
            RANGE_X1:  decade_scale = DECADE_SCALE_0;
            RANGE_X10: decade_scale = DECADE_SCALE_1;
            default:   decade_scale = DECADE_SCALE_2;
        endcase
    endfunction

endpackage

// File: rtl/freq_gate_sequencer_gate_timer.sv
// Loadable down-counter with terminal-count flag; times both the gate window
// and the post-gate settle interval.
module freq_gate_sequencer_gate_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the last cycle of a loaded interval, so a load of N spans N cycles.
    assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/freq_gate_sequencer.sv
// Gated-counter frequency measurement sequencer with display handshake.
// Optional decade autoranging is enabled by FREQ_GATE_SEQUENCER_AUTORANGE_EN.
//
// state  | meaning
// IDLE   | waiting for enable
// CLEAR  | one-cycle clear pulse to the external counter
// GATE   | counter gated on for GATE_CYCLES*10^range cycles
// SETTLE | gate closed, waiting for the synchronized count to settle
// LATCH  | capture count, overflow flag and range
// REQ    | result offered to the display until acknowledged
module freq_gate_sequencer
    import freq_gate_sequencer_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CW            = 24,
    parameter int unsigned LOW_THRESH    = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [CW-1:0] cnt_value,
    output logic          cnt_clear,
    output logic          gate_en,
    output logic [CW-1:0] result,
    output logic          overflow,
    output logic [1:0]    range,
    output logic          disp_req,
    input  logic          disp_ack
);

    localparam int unsigned GATE_TW = $clog2(GATE_CYCLES * 100 + 1);
    localparam int unsigned SET_TW  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW      = (GATE_TW > SET_TW) ? GATE_TW : SET_TW;

    state_e        state_q, state_d;
    logic          cnt_clear_q, cnt_clear_d;
    logic          gate_en_q, gate_en_d;
    logic          disp_req_q, disp_req_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] result_q, result_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_tc;
    logic [TW-1:0] gate_len;

`ifdef FREQ_GATE_SEQUENCER_AUTORANGE_EN
    localparam logic [CW-1:0] LOW_T = CW'(LOW_THRESH);

    // gate_range_q sets the next gate; range_q reports the range of the latched result.
    logic [1:0] gate_range_q, gate_range_d;
    logic [1:0] range_q, range_d;

    assign gate_len = TW'(GATE_CYCLES * decade_scale(gate_range_q));

    always_comb begin
        gate_range_d = gate_range_q;
        range_d      = range_q;
        if (state_q == ST_LATCH) begin
            range_d = gate_range_q;
            if ((&cnt_value) && (gate_range_q != RANGE_X1)) begin
                gate_range_d = gate_range_q - 2'd1;
            end else if ((cnt_value < LOW_T) && (gate_range_q < RANGE_MAX)) begin
                gate_range_d = gate_range_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_range_q <= RANGE_X1;
            range_q      <= RANGE_X1;
        end else begin
            gate_range_q <= gate_range_d;
            range_q      <= range_d;
        end
    end

    assign range = range_q;
`else
    assign gate_len = TW'(GATE_CYCLES);
    assign range    = RANGE_X1;
`endif

    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        overflow_d   = overflow_q;
        tmr_load     = 1'b0;
        tmr_load_val = gate_len;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                tmr_load = 1'b1;
                state_d  = enable ? ST_GATE : ST_IDLE;
            end
            ST_GATE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tmr_tc) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(SETTLE_CYCLES);
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tmr_tc) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                result_d   = cnt_value;
                overflow_d = &cnt_value;
                state_d    = ST_REQ;
            end
            ST_REQ: begin
                if (disp_ack) state_d = enable ? ST_CLEAR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        cnt_clear_d = (state_d == ST_CLEAR);
        gate_en_d   = (state_d == ST_GATE);
        disp_req_d  = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_clear_q <= 1'b0;
            gate_en_q   <= 1'b0;
            disp_req_q  <= 1'b0;
            overflow_q  <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_clear_q <= cnt_clear_d;
            gate_en_q   <= gate_en_d;
            disp_req_q  <= disp_req_d;
            overflow_q  <= overflow_d;
            result_q    <= result_d;
        end
    end

    freq_gate_sequencer_gate_timer #(
        .W(TW)
    ) u_gate_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .tc      (tmr_tc)
    );

    assign cnt_clear = cnt_clear_q;
    assign gate_en   = gate_en_q;
    assign disp_req  = disp_req_q;
    assign overflow  = overflow_q;
    assign result    = result_q;

endmodule
